// File: rtl/morra_pkg.sv
// morra_pkg: shared result/state types and the odd-difference winner rule
package morra_pkg;
  typedef enum logic [1:0] {NULLA = 2'b00, VINCE1 = 2'b01, VINCE2 = 2'b10, PAREGGIO = 2'b11} esito_t;
  typedef enum logic [1:0] {IDLE, GIOCO, FINE} stato_t;
  function automatic logic vince(input int a, input int b, input int n);
    int d;
    d = (a - b + n) % n;
    return d[0];
  endfunction
endpackage

// File: rtl/morra_arbitro.sv
// morra_arbitro: judges one manche; repeat restriction under MORRA_NO_REPEAT_EN
import morra_pkg::*;
module morra_arbitro #(
  parameter int NUM_MOSSE = 3,
  parameter int MOSSA_W   = 2
) (
  input  logic [MOSSA_W-1:0] a,
  input  logic [MOSSA_W-1:0] b,
`ifdef MORRA_NO_REPEAT_EN
  input  esito_t             ultimo,
  input  logic [MOSSA_W-1:0] mossa_vinc,
`endif
  output esito_t             esito,
  output logic               valido
);
  localparam logic [MOSSA_W-1:0] N_M = MOSSA_W'(NUM_MOSSE);
  logic legale, ripete;
  // legality, repeat check and winner selection
  always_comb begin
    legale = a != '0 && b != '0 && a <= N_M && b <= N_M;
`ifdef MORRA_NO_REPEAT_EN
    ripete = (ultimo == VINCE1 && a == mossa_vinc) || (ultimo == VINCE2 && b == mossa_vinc);
`else
    ripete = 1'b0;
`endif
    valido = legale && !ripete;
    esito = !valido ? NULLA : a == b ? PAREGGIO : vince(int'(a), int'(b), NUM_MOSSE) ? VINCE1 : VINCE2;
  end
endmodule

// File: rtl/morra_cinese_param.sv
// morra_cinese_param: parametrised morra cinese match FSM (option: MORRA_NO_REPEAT_EN)
import morra_pkg::*;
module morra_cinese_param #(
  parameter int NUM_MOSSE  = 3,
  parameter int MIN_MANCHE = 4,
  parameter int VANTAGGIO  = 2,
  parameter int MOSSA_W    = $clog2(NUM_MOSSE + 1),
  parameter int CNT_W      = $clog2(MIN_MANCHE + 2 ** (2 * MOSSA_W) + 1)
) (
  input  logic               clk,
  input  logic               INIZIO,
  input  logic [MOSSA_W-1:0] PRIMO,
  input  logic [MOSSA_W-1:0] SECONDO,
  output logic [1:0]         MANCHE,
  output logic [1:0]         PARTITA,
  output logic [CNT_W-1:0]   PUNTI1,
  output logic [CNT_W-1:0]   PUNTI2,
  output logic [CNT_W-1:0]   GIOCATE
);
  stato_t stato;
  esito_t manche_q, partita_q, esito, fine_n;
  logic valido;
  logic [CNT_W-1:0] p1, p2, g, maxm, p1n, p2n, gn;
`ifdef MORRA_NO_REPEAT_EN
  esito_t ultimo;
  logic [MOSSA_W-1:0] mossa_vinc;
`endif
  morra_arbitro #(.NUM_MOSSE(NUM_MOSSE), .MOSSA_W(MOSSA_W)) u_arbitro (
    .a(PRIMO),
    .b(SECONDO),
`ifdef MORRA_NO_REPEAT_EN
    .ultimo(ultimo),
    .mossa_vinc(mossa_vinc),
`endif
    .esito(esito),
    .valido(valido)
  );
  // post-update counts and the end-of-match decision taken on them
  always_comb begin
    p1n = p1 + CNT_W'(esito == VINCE1);
    p2n = p2 + CNT_W'(esito == VINCE2);
    gn = g + CNT_W'(valido);
    fine_n = int'(p1n) >= int'(p2n) + VANTAGGIO ? VINCE1 :
             int'(p2n) >= int'(p1n) + VANTAGGIO ? VINCE2 :
             gn == maxm ? (p1n > p2n ? VINCE1 : p2n > p1n ? VINCE2 : PAREGGIO) : NULLA;
  end
  // match state, registered results, counters and winner memory
  always_ff @(posedge clk) begin
    if (INIZIO) begin
      stato <= GIOCO;
      manche_q <= NULLA;
      partita_q <= NULLA;
      p1 <= '0;
      p2 <= '0;
      g <= '0;
      maxm <= CNT_W'(MIN_MANCHE) + CNT_W'({PRIMO, SECONDO});
`ifdef MORRA_NO_REPEAT_EN
      ultimo <= NULLA;
      mossa_vinc <= '0;
`endif
    end else if (stato == GIOCO) begin
      manche_q <= esito;
      partita_q <= fine_n;
      p1 <= p1n;
      p2 <= p2n;
      g <= gn;
      if (fine_n != NULLA) stato <= FINE;
`ifdef MORRA_NO_REPEAT_EN
      if (esito == VINCE1 || esito == VINCE2) begin
        ultimo <= esito;
        mossa_vinc <= esito == VINCE1 ? PRIMO : SECONDO;
      end
`endif
    end else if (stato == FINE) begin
      manche_q <= NULLA;
    end
  end
  assign MANCHE = manche_q;
  assign PARTITA = partita_q;
  assign PUNTI1 = p1;
  assign PUNTI2 = p2;
  assign GIOCATE = g;
endmodule

// File: tb/tb_morra_cinese_param.sv
// tb_morra_cinese_param: directed checks of the 3-move and 5-move match FSM
module tb_morra_cinese_param;
  logic clk = 1'b0;
  logic inizio = 1'b0;
  logic [1:0] primo = '0, secondo = '0, manche, partita;
  logic [4:0] p1, p2, g;
  logic [2:0] primo5 = '0, secondo5 = '0;
  logic [1:0] manche5, partita5;
  logic [6:0] p15, p25, g5;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  morra_cinese_param u (
    .clk(clk), .INIZIO(inizio), .PRIMO(primo), .SECONDO(secondo),
    .MANCHE(manche), .PARTITA(partita), .PUNTI1(p1), .PUNTI2(p2), .GIOCATE(g)
  );

  morra_cinese_param #(.NUM_MOSSE(5)) u5 (
    .clk(clk), .INIZIO(inizio), .PRIMO(primo5), .SECONDO(secondo5),
    .MANCHE(manche5), .PARTITA(partita5), .PUNTI1(p15), .PUNTI2(p25), .GIOCATE(g5)
  );

  task automatic step(input logic ini, input logic [2:0] p, input logic [2:0] s);
    @(negedge clk);
    inizio = ini;
    primo = p[1:0];
    secondo = s[1:0];
    primo5 = p;
    secondo5 = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    step(1, 0, 0);
    chk("rst_manche", int'(manche), 0);
    chk("rst_partita", int'(partita), 0);
    chk("rst_p1", int'(p1), 0);
    chk("rst_p2", int'(p2), 0);
    chk("rst_g", int'(g), 0);
    step(0, 2, 1);
    chk("w1_manche", int'(manche), 1);
    chk("w1_p1", int'(p1), 1);
    chk("w1_g", int'(g), 1);
    chk("w1_partita", int'(partita), 0);
    step(0, 3, 2);
    chk("w2_manche", int'(manche), 1);
    chk("w2_partita", int'(partita), 1);
    chk("w2_p1", int'(p1), 2);
    step(0, 1, 1);
    chk("fine_manche", int'(manche), 0);
    chk("fine_partita", int'(partita), 1);
    chk("fine_g", int'(g), 2);
    step(1, 0, 0);
    step(0, 1, 1);
    step(0, 2, 2);
    step(0, 3, 3);
    chk("tie3_partita", int'(partita), 0);
    chk("tie3_g", int'(g), 3);
    step(0, 1, 1);
    chk("tie4_manche", int'(manche), 3);
    chk("tie4_partita", int'(partita), 3);
    chk("tie4_g", int'(g), 4);
    step(1, 0, 0);
    step(0, 2, 1);
    step(0, 0, 2);
    chk("inv1_manche", int'(manche), 0);
    chk("inv1_g", int'(g), 1);
    chk("inv1_p1", int'(p1), 1);
    chk("inv1_partita", int'(partita), 0);
    step(0, 3, 0);
    chk("inv2_manche", int'(manche), 0);
    chk("inv2_g", int'(g), 1);
    step(1, 1, 2);
    chk("cfg_g", int'(g), 0);
    chk("cfg_p1", int'(p1), 0);
    for (int i = 1; i <= 10; i++) begin
      if (i % 2 == 1) step(0, 2, 1);
      else step(0, 1, 2);
      chk($sformatf("alt%0d_manche", i), int'(manche), i % 2 == 1 ? 1 : 2);
      chk($sformatf("alt%0d_g", i), int'(g), i);
      chk($sformatf("alt%0d_partita", i), int'(partita), i == 10 ? 3 : 0);
    end
    chk("alt_p1", int'(p1), 5);
    chk("alt_p2", int'(p2), 5);
    step(1, 0, 0);
    step(0, 2, 1);
    chk("rep_first", int'(manche), 1);
    step(0, 2, 3);
`ifdef MORRA_NO_REPEAT_EN
    chk("rep_manche", int'(manche), 0);
    chk("rep_g", int'(g), 1);
`else
    chk("rep_manche", int'(manche), 2);
    chk("rep_g", int'(g), 2);
`endif
    step(1, 0, 0);
    chk("n5_rst_g", int'(g5), 0);
    step(0, 6, 1);
    chk("n5_inv_manche", int'(manche5), 0);
    chk("n5_inv_g", int'(g5), 0);
    step(0, 3, 2);
    chk("n5_win_manche", int'(manche5), 1);
    chk("n5_win_p1", int'(p15), 1);
    step(0, 5, 1);
    chk("n5_p2_manche", int'(manche5), 2);
    chk("n5_p2_g", int'(g5), 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
